wb_ram_host_bridge: RTL and testbench

Wishbone classic slave that lets the management core read and write the uP16 program/data RAM (1024 x 16 OpenRAM macro) and control CPU access to it. It provides a control/status register pair and a 4 KB RAM window. Its outputs drive the SoC memory mux: when host mode is on, this block owns the RAM port and the CPU path is disconnected. RAM control strobes are active-low, matching the OpenRAM macro.

---
 rtl/wb_ram_host_bridge.sv | 170 +++++++++++++++++
 tb/tb_wb_ram_host_bridge.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_ram_host_bridge.sv
// Wishbone classic slave that gives the management core access to the uP16
// program/data RAM and to a small control/status register pair.
module wb_ram_host_bridge #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int unsigned AW        = 10,
  parameter int unsigned DW        = 16
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_ni,
  input  logic          wbs_stb_i,
  input  logic          wbs_cyc_i,
  input  logic          wbs_we_i,
  input  logic [3:0]    wbs_sel_i,
  input  logic [31:0]   wbs_adr_i,
  input  logic [31:0]   wbs_dat_i,
  output logic          wbs_ack_o,
  output logic [31:0]   wbs_dat_o,
  output logic          mem_csb_o,
  output logic          mem_web_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_din_o,
  input  logic [DW-1:0] mem_dout_i,
  output logic          host_mode_o,
  output logic          cpu_hold_o,
  output logic          busy_o
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REG     = 3'd1,
    RAM_WR  = 3'd2,
    RAM_RD  = 3'd3,
    RAM_RDW = 3'd4,
    ACK     = 3'd5
  } state_t;

  state_t state, state_next;

  logic        live;
  logic        req;
  logic        in_window;
  logic [15:0] off_q;
  logic        we_q;
  logic [15:0] wrcnt;
  logic [31:0] reg_rdata;
  logic        unused_inputs;

  assign live      = wbs_cyc_i && wbs_stb_i;
  assign req       = live && (wbs_adr_i[31:16] == BASE_ADDR[31:16]);
  assign in_window = (wbs_adr_i[15:12] == 4'h1);
  assign busy_o    = (state != IDLE);

  assign unused_inputs = ^{wbs_sel_i, wbs_dat_i, wbs_adr_i};

  // Register-side read data, selected by the offset latched at request time.
  always_comb begin
    reg_rdata = '0;
    if (off_q == 16'h0000) begin
      reg_rdata = {30'd0, cpu_hold_o, host_mode_o};
    end else if (off_q == 16'h0004) begin
      reg_rdata = {15'd0, host_mode_o, wrcnt};
    end else if (off_q[15:12] == 4'h1) begin
      reg_rdata = 32'h0000_DEAD;
    end
  end

  // Next-state decode plus the ack/read-data bus; ack is gated by the live
  // strobe so a master that drops stb early never sees an ack.
  always_comb begin
    state_next = state;
    wbs_ack_o  = 1'b0;
    wbs_dat_o  = '0;
    case (state)
      IDLE: begin
        if (req) begin
          if (in_window && host_mode_o) begin
            if (!wbs_we_i)                 state_next = RAM_RD;
            else if (wbs_sel_i[1:0] != '0) state_next = RAM_WR;
            else                           state_next = REG;
          end else begin
            state_next = REG;
          end
        end
      end
      REG: begin
        if (live) begin
          wbs_ack_o  = 1'b1;
          if (!we_q) wbs_dat_o = reg_rdata;
          state_next = ACK;
        end else begin
          state_next = IDLE;
        end
      end
      // The RAM write ack reuses REG; its latched offset is in the window,
      // so REG has no register side effect for it.
      RAM_WR:  state_next = live ? REG : IDLE;
      RAM_RD:  state_next = live ? RAM_RDW : IDLE;
      RAM_RDW: begin
        if (live) begin
          wbs_ack_o  = 1'b1;
          wbs_dat_o  = 32'(mem_dout_i);
          state_next = ACK;
        end else begin
          state_next = IDLE;
        end
      end
      ACK:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) state <= IDLE;
    else            state <= state_next;
  end

  // RAM strobes are registered from the next state so they only move on edges.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      mem_csb_o <= 1'b1;
      mem_web_o <= 1'b1;
    end else begin
      mem_csb_o <= !((state_next == RAM_WR) || (state_next == RAM_RD));
      mem_web_o <= !(state_next == RAM_WR);
    end
  end

  // RAM address/data load only when a strobe starts and hold otherwise.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      mem_addr_o <= '0;
      mem_din_o  <= '0;
    end else begin
      if ((state_next == RAM_WR) || (state_next == RAM_RD))
        mem_addr_o <= wbs_adr_i[AW+1:2];
      if (state_next == RAM_WR)
        mem_din_o <= wbs_dat_i[DW-1:0];
    end
  end

  // Capture the request offset and direction when a request is accepted.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      off_q <= '0;
      we_q  <= 1'b0;
    end else if (state == IDLE && req) begin
      off_q <= wbs_adr_i[15:0];
      we_q  <= wbs_we_i;
    end
  end

  // Count every issued RAM write strobe, including aborted ones.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni)            wrcnt <= '0;
    else if (state == RAM_WR)  wrcnt <= wrcnt + 16'd1;
  end

  // CTRL updates only on a completed (acked) write.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      host_mode_o <= 1'b0;
      cpu_hold_o  <= 1'b0;
    end else if (state == REG && live && we_q && off_q == 16'h0000) begin
      host_mode_o <= wbs_dat_i[0];
      cpu_hold_o  <= wbs_dat_i[1];
    end
  end

endmodule

// File: tb/tb_wb_ram_host_bridge.sv
// Self-checking bench for wb_ram_host_bridge: vector table plus hand-written
// abort, protocol, wrap and reset sequences, with a behavioural RAM model.
module tb_wb_ram_host_bridge;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [3:0]  sel = '0;
  logic [31:0] adr = '0, dat_w = '0;
  logic        ack;
  logic [31:0] dat_r;
  logic        csb, web;
  logic [9:0]  maddr;
  logic [15:0] mdin;
  logic [15:0] mdout = '0;
  logic        host, hold, busy;

  int passed = 0;
  int total  = 0;
  int ack_count = 0;

  always #5 clk = ~clk;

  wb_ram_host_bridge #(.BASE_ADDR(32'h3000_0000), .AW(10), .DW(16)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(dat_w), .wbs_ack_o(ack), .wbs_dat_o(dat_r),
    .mem_csb_o(csb), .mem_web_o(web), .mem_addr_o(maddr), .mem_din_o(mdin),
    .mem_dout_i(mdout), .host_mode_o(host), .cpu_hold_o(hold), .busy_o(busy)
  );

  // RAM model: 1024 x 16, read data valid one cycle after csb sampled low.
  logic [15:0] ram [0:1023];
  always @(posedge clk) begin
    if (!csb) begin
      if (!web) ram[maddr] <= mdin;
      else      mdout <= ram[maddr];
    end
  end

  typedef struct { logic [9:0] addr; logic web; logic [15:0] din; } strb_t;
  strb_t strobes[$];

  // Record every RAM strobe seen by the macro.
  always @(posedge clk) begin
    if (!csb) strobes.push_back('{maddr, web, mdin});
  end

  // Count ack cycles.
  always @(negedge clk) begin
    if (ack) ack_count++;
  end

  typedef struct {
    logic [31:0] adr; logic we; logic [31:0] dat; logic [3:0] sel;
    logic [31:0] exp_rd; int exp_lat; int exp_strb;
    logic [9:0] exp_addr; logic [15:0] exp_din; logic exp_host; logic exp_hold;
  } vec_t;

  typedef struct { logic [31:0] data; int lat; logic chk_data; } exp_t;
  exp_t sb[$];

  function automatic vec_t mk(input logic [31:0] a, input logic w, input logic [31:0] d,
                              input logic [3:0] s, input logic [31:0] rd, input int lat,
                              input int ns, input logic [9:0] sa, input logic [15:0] sd,
                              input logic h, input logic c);
    vec_t v;
    v.adr = a; v.we = w; v.dat = d; v.sel = s; v.exp_rd = rd; v.exp_lat = lat;
    v.exp_strb = ns; v.exp_addr = sa; v.exp_din = sd; v.exp_host = h; v.exp_hold = c;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  task automatic bus_start(input logic [31:0] a, input logic w, input logic [31:0] d,
                           input logic [3:0] s);
    @(negedge clk);
    adr = a; we = w; dat_w = d; sel = s; cyc = 1'b1; stb = 1'b1;
  endtask

  task automatic bus_stop();
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  // Lat = number of rising edges that sample stb up to and including the one
  // that sees ack. hold = extra cycles stb stays high after the ack edge.
  task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] d,
                      input logic [3:0] s, input int hold_cyc,
                      output logic got, output logic [31:0] rd, output int lat);
    bus_start(a, w, d, s);
    got = 1'b0; rd = '0; lat = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (ack) begin got = 1'b1; rd = dat_r; lat = k + 1; break; end
    end
    if (got) begin
      @(negedge clk);
      repeat (hold_cyc) @(negedge clk);
    end
    bus_stop();
  endtask

  task automatic reg_read(input string name, input logic [31:0] a, input logic [31:0] exp);
    logic g; logic [31:0] r; int l;
    xfer(a, 1'b0, '0, 4'hF, 0, g, r, l);
    check({name, ".ack"}, 32'(g), 32'd1);
    check({name, ".data"}, r, exp);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vec_t  vecs[$];
    vec_t  v;
    exp_t  e;
    strb_t st;
    logic  got;
    logic [31:0] rd;
    int    lat, ab, sbase;

    vecs.push_back(mk(32'h3000_0000, 1, 32'h0000_0003, 4'hF, 32'h0,          2, 0, 10'h000, 16'h0000, 1, 1));
    vecs.push_back(mk(32'h3000_0000, 0, 32'h0,         4'hF, 32'h0000_0003,  2, 0, 10'h000, 16'h0000, 1, 1));
    vecs.push_back(mk(32'h3000_0004, 0, 32'h0,         4'hF, 32'h0001_0000,  2, 0, 10'h000, 16'h0000, 1, 1));
    vecs.push_back(mk(32'h3000_1008, 1, 32'h0000_BEEF, 4'hF, 32'h0,          3, 1, 10'h002, 16'hBEEF, 1, 1));
    vecs.push_back(mk(32'h3000_1008, 0, 32'h0,         4'hF, 32'h0000_BEEF,  3, 1, 10'h002, 16'h0000, 1, 1));
    vecs.push_back(mk(32'h3000_0004, 0, 32'h0,         4'hF, 32'h0001_0001,  2, 0, 10'h000, 16'h0000, 1, 1));
    vecs.push_back(mk(32'h3000_1FFC, 1, 32'hFFFF_1234, 4'hF, 32'h0,          3, 1, 10'h3FF, 16'h1234, 1, 1));
    vecs.push_back(mk(32'h3000_1FFC, 0, 32'h0,         4'hF, 32'h0000_1234,  3, 1, 10'h3FF, 16'h0000, 1, 1));
    vecs.push_back(mk(32'h3000_1010, 1, 32'h0000_5555, 4'hC, 32'h0,          2, 0, 10'h000, 16'h0000, 1, 1));
    vecs.push_back(mk(32'h3000_0004, 0, 32'h0,         4'hF, 32'h0001_0002,  2, 0, 10'h000, 16'h0000, 1, 1));
    vecs.push_back(mk(32'h3000_0004, 1, 32'hFFFF_FFFF, 4'hF, 32'h0,          2, 0, 10'h000, 16'h0000, 1, 1));
    vecs.push_back(mk(32'h3000_0004, 0, 32'h0,         4'hF, 32'h0001_0002,  2, 0, 10'h000, 16'h0000, 1, 1));
    vecs.push_back(mk(32'h3000_0100, 0, 32'h0,         4'hF, 32'h0,          2, 0, 10'h000, 16'h0000, 1, 1));
    vecs.push_back(mk(32'h3000_0100, 1, 32'h0000_0000, 4'hF, 32'h0,          2, 0, 10'h000, 16'h0000, 1, 1));
    vecs.push_back(mk(32'h3000_0000, 1, 32'h0000_0000, 4'hF, 32'h0,          2, 0, 10'h000, 16'h0000, 0, 0));
    vecs.push_back(mk(32'h3000_1000, 0, 32'h0,         4'hF, 32'h0000_DEAD,  2, 0, 10'h000, 16'h0000, 0, 0));
    vecs.push_back(mk(32'h3000_1000, 1, 32'h0000_AAAA, 4'hF, 32'h0,          2, 0, 10'h000, 16'h0000, 0, 0));
    vecs.push_back(mk(32'h3000_0004, 0, 32'h0,         4'hF, 32'h0000_0002,  2, 0, 10'h000, 16'h0000, 0, 0));
    vecs.push_back(mk(32'h3000_0000, 0, 32'h0,         4'hF, 32'h0000_0000,  2, 0, 10'h000, 16'h0000, 0, 0));
    vecs.push_back(mk(32'h3000_0000, 1, 32'h0000_0001, 4'hF, 32'h0,          2, 0, 10'h000, 16'h0000, 1, 0));
    vecs.push_back(mk(32'h3000_0000, 0, 32'h0,         4'hF, 32'h0000_0001,  2, 0, 10'h000, 16'h0000, 1, 0));

    // Reset state
    repeat (2) @(negedge clk);
    check("rst.csb", 32'(csb), 32'd1);
    check("rst.web", 32'(web), 32'd1);
    check("rst.ack", 32'(ack), 32'd0);
    check("rst.dat", dat_r, 32'h0);
    check("rst.host", 32'(host), 32'd0);
    check("rst.hold", 32'(hold), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.addr", 32'(maddr), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Vector table
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      ab = ack_count;
      sbase = strobes.size();
      sb.push_back('{v.exp_rd, v.exp_lat, !v.we});
      xfer(v.adr, v.we, v.dat, v.sel, 0, got, rd, lat);
      e = sb.pop_front();
      check($sformatf("v%0d.ack", i), 32'(got), 32'd1);
      if (got) begin
        check($sformatf("v%0d.lat", i), 32'(lat), 32'(e.lat));
        if (e.chk_data) check($sformatf("v%0d.rdata", i), rd, e.data);
      end
      repeat (2) @(negedge clk);
      check($sformatf("v%0d.acks", i), 32'(ack_count - ab), 32'd1);
      check($sformatf("v%0d.strobes", i), 32'(strobes.size() - sbase), 32'(v.exp_strb));
      if (v.exp_strb == 1 && strobes.size() > sbase) begin
        st = strobes[sbase];
        check($sformatf("v%0d.saddr", i), 32'(st.addr), 32'(v.exp_addr));
        check($sformatf("v%0d.sweb", i), 32'(st.web), 32'(!v.we));
        if (v.we) check($sformatf("v%0d.sdin", i), 32'(st.din), 32'(v.exp_din));
      end
      check($sformatf("v%0d.host", i), 32'(host), 32'(v.exp_host));
      check($sformatf("v%0d.hold", i), 32'(hold), 32'(v.exp_hold));
      check($sformatf("v%0d.busy", i), 32'(busy), 32'd0);
    end
    check("hold_addr", 32'(maddr), 32'h3FF);

    // stb held an extra cycle after ack: still exactly one ack and one strobe
    ab = ack_count; sbase = strobes.size();
    xfer(32'h3000_1020, 1'b1, 32'h0000_0077, 4'hF, 1, got, rd, lat);
    repeat (3) @(negedge clk);
    check("ext_stb.acks", 32'(ack_count - ab), 32'd1);
    check("ext_stb.strobes", 32'(strobes.size() - sbase), 32'd1);
    check("ext_stb.busy", 32'(busy), 32'd0);

    // Foreign base address: ignored
    ab = ack_count;
    xfer(32'h3100_0000, 1'b0, '0, 4'hF, 0, got, rd, lat);
    check("bad_base.noack", 32'(got), 32'd0);
    check("bad_base.acks", 32'(ack_count - ab), 32'd0);
    check("bad_base.busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);

    // stb dropped during RAM_RD: strobe completes, no ack
    ab = ack_count; sbase = strobes.size();
    bus_start(32'h3000_1008, 1'b0, '0, 4'hF);
    @(negedge clk);
    check("abort_rd.csb_low", 32'(csb), 32'd0);
    bus_stop();
    repeat (3) @(negedge clk);
    check("abort_rd.acks", 32'(ack_count - ab), 32'd0);
    check("abort_rd.strobes", 32'(strobes.size() - sbase), 32'd1);
    check("abort_rd.busy", 32'(busy), 32'd0);
    check("abort_rd.csb", 32'(csb), 32'd1);

    // stb dropped during RAM_WR: write lands and is counted
    ab = ack_count;
    bus_start(32'h3000_100C, 1'b1, 32'h0000_0099, 4'hF);
    @(negedge clk);
    bus_stop();
    repeat (3) @(negedge clk);
    check("abort_wr.acks", 32'(ack_count - ab), 32'd0);
    reg_read("abort_wr.status", 32'h3000_0004, 32'h0001_0004);
    reg_read("abort_wr.readback", 32'h3000_100C, 32'h0000_0099);

    // WRCNT wrap
    force dut.wrcnt = 16'hFFFF;
    @(negedge clk);
    release dut.wrcnt;
    reg_read("wrap.pre", 32'h3000_0004, 32'h0001_FFFF);
    xfer(32'h3000_1004, 1'b1, 32'h0000_0001, 4'hF, 0, got, rd, lat);
    check("wrap.ack", 32'(got), 32'd1);
    repeat (2) @(negedge clk);
    reg_read("wrap.post", 32'h3000_0004, 32'h0001_0000);

    // Reset in the middle of RAM_RD
    bus_start(32'h3000_1008, 1'b0, '0, 4'hF);
    @(negedge clk);
    check("rst_rd.csb_low", 32'(csb), 32'd0);
    rst_n = 1'b0;
    #1;
    check("rst_rd.csb", 32'(csb), 32'd1);
    check("rst_rd.web", 32'(web), 32'd1);
    check("rst_rd.ack", 32'(ack), 32'd0);
    check("rst_rd.host", 32'(host), 32'd0);
    check("rst_rd.dat", dat_r, 32'h0);
    check("rst_rd.busy", 32'(busy), 32'd0);
    bus_stop();
    @(negedge clk);
    rst_n = 1'b1;
    ab = ack_count;
    repeat (4) @(negedge clk);
    check("rst_rd.noack", 32'(ack_count - ab), 32'd0);
    reg_read("rst_rd.status", 32'h3000_0004, 32'h0000_0000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
